// File: rtl/wshb_arbiter_2_pkg.sv
// wshb_arb_pkg: shared types for the two-master SDRAM Wishbone arbiter.
//   arb_state_t : arbiter FSM state; the encoding doubles as the one-hot grant.
//   NB_MASTERS  : number of masters sharing the slave port.
package wshb_arb_pkg;

  localparam int NB_MASTERS = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } arb_state_t;

endpackage

// File: rtl/wshb_arbiter_2_if.sv
// wshb_if: Wishbone B4 bus bundle (classic + burst tags).
//   master modport : drives cyc/stb/we/adr/dat_ms/sel/cti/bte, receives dat_sm/ack/err/rty
//   slave modport  : the mirror image
// DATA_BYTES sets the data bus width (8*DATA_BYTES bits) and the sel width.
interface wshb_if #(parameter int DATA_BYTES = 4) ();

  logic                      cyc;
  logic                      stb;
  logic                      we;
  logic [31:0]               adr;
  logic [8*DATA_BYTES-1:0]   dat_ms;
  logic [8*DATA_BYTES-1:0]   dat_sm;
  logic [DATA_BYTES-1:0]     sel;
  logic [2:0]                cti;
  logic [1:0]                bte;
  logic                      ack;
  logic                      err;
  logic                      rty;

  modport master (
    output cyc, stb, we, adr, dat_ms, sel, cti, bte,
    input  dat_sm, ack, err, rty
  );

  modport slave (
    input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
    output dat_sm, ack, err, rty
  );

endinterface

// File: rtl/wshb_arbiter_2.sv
// wshb_arbiter_2: round-robin arbiter letting two Wishbone masters share the
// single SDRAM slave port, in the sys_clk domain.
//   sys_clk    : system clock (100 MHz)
//   sys_rst    : asynchronous active-high reset
//   wshb_ifs_0 : slave port facing master 0 (video stream reader)
//   wshb_ifs_1 : slave port facing master 1 (frame writer)
//   wshb_ifm   : master port facing the SDRAM slave
//   grant      : one-hot current owner (01 = master 0, 10 = master 1, 00 = idle)
//
//   state | meaning
//   IDLE  | no owner, slave bus forced to zero
//   GNT0  | master 0 owns the bus until it drops cyc
//   GNT1  | master 1 owns the bus until it drops cyc
module wshb_arbiter_2
  import wshb_arb_pkg::*;
#(
  parameter int DATA_BYTES = 4
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  wshb_if.slave                 wshb_ifs_0,
  wshb_if.slave                 wshb_ifs_1,
  wshb_if.master                wshb_ifm,
  output logic [NB_MASTERS-1:0] grant
);

  arb_state_t state;
  logic       prio;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
      prio  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wshb_ifs_0.cyc && wshb_ifs_1.cyc) state <= prio ? GNT1 : GNT0;
          else if (wshb_ifs_0.cyc)               state <= GNT0;
          else if (wshb_ifs_1.cyc)               state <= GNT1;
        end
        GNT0: begin
          if (!wshb_ifs_0.cyc) begin
            prio  <= 1'b1;
            state <= wshb_ifs_1.cyc ? GNT1 : IDLE;
          end
        end
        GNT1: begin
          if (!wshb_ifs_1.cyc) begin
            prio  <= 1'b0;
            state <= wshb_ifs_0.cyc ? GNT0 : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The state register is the grant; no separate flop needed.
  assign grant = state;

  // Forward path follows the owner's live cyc, so the release cycle already
  // shows cyc low on the slave side and owners are always separated by a gap.
  always_comb begin
    wshb_ifm.cyc    = 1'b0;
    wshb_ifm.stb    = 1'b0;
    wshb_ifm.we     = 1'b0;
    wshb_ifm.adr    = 32'd0;
    wshb_ifm.dat_ms = {(8*DATA_BYTES){1'b0}};
    wshb_ifm.sel    = {DATA_BYTES{1'b0}};
    wshb_ifm.cti    = 3'd0;
    wshb_ifm.bte    = 2'd0;
    wshb_ifs_0.ack  = 1'b0;
    wshb_ifs_0.err  = 1'b0;
    wshb_ifs_0.rty  = 1'b0;
    wshb_ifs_1.ack  = 1'b0;
    wshb_ifs_1.err  = 1'b0;
    wshb_ifs_1.rty  = 1'b0;
    // Read data is only meaningful alongside ack, so it can go to both.
    wshb_ifs_0.dat_sm = wshb_ifm.dat_sm;
    wshb_ifs_1.dat_sm = wshb_ifm.dat_sm;
    case (state)
      GNT0: begin
        wshb_ifm.cyc    = wshb_ifs_0.cyc;
        wshb_ifm.stb    = wshb_ifs_0.stb;
        wshb_ifm.we     = wshb_ifs_0.we;
        wshb_ifm.adr    = wshb_ifs_0.adr;
        wshb_ifm.dat_ms = wshb_ifs_0.dat_ms;
        wshb_ifm.sel    = wshb_ifs_0.sel;
        wshb_ifm.cti    = wshb_ifs_0.cti;
        wshb_ifm.bte    = wshb_ifs_0.bte;
        wshb_ifs_0.ack  = wshb_ifm.ack;
        wshb_ifs_0.err  = wshb_ifm.err;
        wshb_ifs_0.rty  = wshb_ifm.rty;
      end
      GNT1: begin
        wshb_ifm.cyc    = wshb_ifs_1.cyc;
        wshb_ifm.stb    = wshb_ifs_1.stb;
        wshb_ifm.we     = wshb_ifs_1.we;
        wshb_ifm.adr    = wshb_ifs_1.adr;
        wshb_ifm.dat_ms = wshb_ifs_1.dat_ms;
        wshb_ifm.sel    = wshb_ifs_1.sel;
        wshb_ifm.cti    = wshb_ifs_1.cti;
        wshb_ifm.bte    = wshb_ifs_1.bte;
        wshb_ifs_1.ack  = wshb_ifm.ack;
        wshb_ifs_1.err  = wshb_ifm.err;
        wshb_ifs_1.rty  = wshb_ifm.rty;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wshb_arbiter_2.sv
// Self-checking bench for wshb_arbiter_2: directed scenarios plus a randomized
// run against a bus-ownership reference model.
module tb_wshb_arbiter_2;

  localparam int DB = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [1:0] grant;

  int vectors     = 0;
  int miscompares = 0;

  wshb_if #(.DATA_BYTES(DB)) m0 ();
  wshb_if #(.DATA_BYTES(DB)) m1 ();
  wshb_if #(.DATA_BYTES(DB)) s  ();

  wshb_arbiter_2 #(.DATA_BYTES(DB)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .wshb_ifs_0 (m0),
    .wshb_ifs_1 (m1),
    .wshb_ifm   (s),
    .grant      (grant)
  );

  always #5 sys_clk = ~sys_clk;

  // Master-side stimulus state, one entry per master.
  logic        mc[2], ms[2], mw[2];
  logic [31:0] ma[2], md[2];
  logic [3:0]  msel[2];
  logic [2:0]  mcti[2];
  logic [1:0]  mbte[2];
  int          beats[2];
  logic        resp[2];

  // Slave-side response.
  logic        s_ack, s_err, s_rty;
  logic [31:0] s_dat;

  // Reference model: who owns the bus (-1 = nobody) and whose turn is next.
  int own;
  int prio_m;

  function automatic logic [1:0] own2g(int o);
    if (o < 0) return 2'b00;
    return (o == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic drive_masters();
    m0.cyc = mc[0]; m0.stb = ms[0]; m0.we = mw[0]; m0.adr = ma[0];
    m0.dat_ms = md[0]; m0.sel = msel[0]; m0.cti = mcti[0]; m0.bte = mbte[0];
    m1.cyc = mc[1]; m1.stb = ms[1]; m1.we = mw[1]; m1.adr = ma[1];
    m1.dat_ms = md[1]; m1.sel = msel[1]; m1.cti = mcti[1]; m1.bte = mbte[1];
  endtask

  task automatic drive_slave();
    s.ack = s_ack; s.err = s_err; s.rty = s_rty; s.dat_sm = s_dat;
  endtask

  task automatic model_edge();
    if (sys_rst) begin
      own = -1; prio_m = 0;
    end else if (own < 0) begin
      if (mc[0] && mc[1]) own = prio_m;
      else if (mc[0])     own = 0;
      else if (mc[1])     own = 1;
    end else if (!mc[own]) begin
      prio_m = 1 - own;
      own    = mc[1 - own] ? 1 - own : -1;
    end
  endtask

  task automatic next_cycle();
    @(posedge sys_clk);
    model_edge();
    @(negedge sys_clk);
  endtask

  task automatic clear_masters();
    for (int i = 0; i < 2; i++) begin
      mc[i] = 0; ms[i] = 0; mw[i] = 0; ma[i] = '0; md[i] = '0;
      msel[i] = '0; mcti[i] = '0; mbte[i] = '0; beats[i] = 0; resp[i] = 0;
    end
    drive_masters();
  endtask

  task automatic do_reset();
    clear_masters();
    s_ack = 0; s_err = 0; s_rty = 0; drive_slave();
    sys_rst = 1;
    next_cycle();
    sys_rst = 0;
    next_cycle();
  endtask

  task automatic test_reset();
    sys_rst = 1;
    mc[0] = 1; ms[0] = 1; mc[1] = 1; ms[1] = 1;
    drive_masters();
    s_ack = 1; drive_slave();
    for (int k = 0; k < 4; k++) begin
      #1;
      vectors++;
      if (s.cyc !== 1'b0) begin miscompares++; $display("FAIL rst_cyc: got %b want 0", s.cyc); end
      vectors++;
      if (s.stb !== 1'b0) begin miscompares++; $display("FAIL rst_stb: got %b want 0", s.stb); end
      vectors++;
      if (grant !== 2'b00) begin miscompares++; $display("FAIL rst_grant: got %b want 00", grant); end
      vectors++;
      if (m0.ack !== 1'b0 || m1.ack !== 1'b0) begin
        miscompares++; $display("FAIL rst_ack: got %b%b want 00", m1.ack, m0.ack);
      end
      next_cycle();
    end
    clear_masters();
    s_ack = 0; drive_slave();
    sys_rst = 0;
    next_cycle();
  endtask

  task automatic test_single();
    mc[0] = 1; ms[0] = 1; mw[0] = 0; ma[0] = 32'h100; msel[0] = 4'hf;
    drive_masters();
    #1;
    vectors++;
    if (s.cyc !== 1'b0 || grant !== 2'b00) begin
      miscompares++; $display("FAIL single_latency: got cyc=%b grant=%b want cyc=0 grant=00", s.cyc, grant);
    end
    next_cycle();
    for (int b = 0; b < 4; b++) begin
      s_dat = $urandom; s_ack = 1; drive_slave();
      #1;
      vectors++;
      if (grant !== 2'b01) begin miscompares++; $display("FAIL single_grant: got %b want 01", grant); end
      vectors++;
      if (s.cyc !== 1'b1 || s.adr !== 32'h100 + 32'(4*b)) begin
        miscompares++; $display("FAIL single_fwd: got cyc=%b adr=%h want cyc=1 adr=%h", s.cyc, s.adr, 32'h100 + 32'(4*b));
      end
      vectors++;
      if (m0.ack !== 1'b1 || m0.dat_sm !== s_dat) begin
        miscompares++; $display("FAIL single_ack0: got ack=%b dat=%h want ack=1 dat=%h", m0.ack, m0.dat_sm, s_dat);
      end
      vectors++;
      if (m1.ack !== 1'b0) begin miscompares++; $display("FAIL single_ack1: got %b want 0", m1.ack); end
      s_ack = 0; drive_slave();
      ma[0] = ma[0] + 4; drive_masters();
      next_cycle();
    end
    mc[0] = 0; ms[0] = 0; drive_masters();
    #1;
    vectors++;
    if (s.cyc !== 1'b0) begin miscompares++; $display("FAIL single_release: got %b want 0", s.cyc); end
    next_cycle();
    #1;
    vectors++;
    if (grant !== 2'b00) begin miscompares++; $display("FAIL single_idle: got %b want 00", grant); end
  endtask

  task automatic test_contention();
    do_reset();
    ma[0] = $urandom; mw[0] = 0; msel[0] = 4'($urandom);
    ma[1] = $urandom; mw[1] = 1; msel[1] = 4'($urandom);
    mc[0] = 1; ms[0] = 1; mc[1] = 1; ms[1] = 1;
    drive_masters();
    next_cycle();
    #1;
    vectors++;
    if (grant !== 2'b01 || s.adr !== ma[0]) begin
      miscompares++; $display("FAIL cont_first: got grant=%b adr=%h want 01 adr=%h", grant, s.adr, ma[0]);
    end
    next_cycle();
    mc[0] = 0; ms[0] = 0; drive_masters();
    #1;
    vectors++;
    if (s.cyc !== 1'b0 || grant !== 2'b01) begin
      miscompares++; $display("FAIL cont_gap: got cyc=%b grant=%b want cyc=0 grant=01", s.cyc, grant);
    end
    next_cycle();
    #1;
    vectors++;
    if (grant !== 2'b10 || s.cyc !== 1'b1) begin
      miscompares++; $display("FAIL cont_second: got grant=%b cyc=%b want 10 cyc=1", grant, s.cyc);
    end
    vectors++;
    if (s.adr !== ma[1] || s.we !== 1'b1 || s.sel !== msel[1]) begin
      miscompares++; $display("FAIL cont_fields: got adr=%h we=%b sel=%h want adr=%h we=1 sel=%h",
                              s.adr, s.we, s.sel, ma[1], msel[1]);
    end
    mc[1] = 0; ms[1] = 0; drive_masters();
    next_cycle();
  endtask

  task automatic test_fairness();
    int cnt0, cnt1, ngr;
    logic [1:0] prev, expg;
    do_reset();
    cnt0 = 0; cnt1 = 0; ngr = 0; prev = 2'b00;
    mc[0] = 1; ms[0] = 1; mc[1] = 1; ms[1] = 1;
    for (int n = 0; n < 300 && ngr < 20; n++) begin
      drive_masters();
      #1;
      s_ack = s.cyc && s.stb; drive_slave();
      #1;
      if (grant !== 2'b00 && grant !== prev) begin
        expg = (ngr % 2 == 0) ? 2'b01 : 2'b10;
        vectors++;
        if (grant !== expg) begin miscompares++; $display("FAIL fair_order: grant #%0d got %b want %b", ngr, grant, expg); end
        if (grant == 2'b01) cnt0++;
        else cnt1++;
        ngr++;
      end
      prev = grant;
      if (!mc[0]) begin mc[0] = 1; ms[0] = 1; end
      else if (m0.ack) begin mc[0] = 0; ms[0] = 0; end
      if (!mc[1]) begin mc[1] = 1; ms[1] = 1; end
      else if (m1.ack) begin mc[1] = 0; ms[1] = 0; end
      s_ack = 0; drive_slave();
      next_cycle();
    end
    vectors++;
    if (ngr != 20) begin miscompares++; $display("FAIL fair_timeout: got %0d grants want 20", ngr); end
    vectors++;
    if (cnt0 != 10 || cnt1 != 10) begin
      miscompares++; $display("FAIL fair_count: got %0d/%0d want 10/10", cnt0, cnt1);
    end
    clear_masters();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_wait();
    int bad_ack, bad_gnt;
    do_reset();
    bad_ack = 0; bad_gnt = 0;
    mc[0] = 1; ms[0] = 1; ma[0] = $urandom; drive_masters();
    next_cycle();
    for (int k = 0; k < 50; k++) begin
      if (k == 2) begin mc[1] = 1; ms[1] = 1; ma[1] = $urandom; mw[1] = 1; drive_masters(); end
      s_ack = 1'($urandom_range(0, 1)); drive_slave();
      #1;
      if (m1.ack !== 1'b0) bad_ack++;
      if (grant !== 2'b01) bad_gnt++;
      next_cycle();
    end
    vectors++;
    if (bad_ack != 0) begin miscompares++; $display("FAIL wait_ack1: got %0d cycles with ack1=1 want 0", bad_ack); end
    vectors++;
    if (bad_gnt != 0) begin miscompares++; $display("FAIL wait_hold: got %0d cycles without grant 01 want 0", bad_gnt); end
    s_ack = 0; drive_slave();
    mc[0] = 0; ms[0] = 0; drive_masters();
    #1;
    vectors++;
    if (s.cyc !== 1'b0 || grant !== 2'b01) begin
      miscompares++; $display("FAIL wait_gap: got cyc=%b grant=%b want cyc=0 grant=01", s.cyc, grant);
    end
    next_cycle();
    #1;
    vectors++;
    if (grant !== 2'b10 || s.adr !== ma[1]) begin
      miscompares++; $display("FAIL wait_handoff: got grant=%b adr=%h want 10 adr=%h", grant, s.adr, ma[1]);
    end
  endtask

  // Entered while master 1 owns the bus (left that way by test_wait).
  task automatic test_async_reset();
    @(negedge sys_clk);
    #1;
    vectors++;
    if (s.cyc !== 1'b1 || grant !== 2'b10) begin
      miscompares++; $display("FAIL arst_pre: got cyc=%b grant=%b want cyc=1 grant=10", s.cyc, grant);
    end
    #2 sys_rst = 1;
    #1;
    vectors++;
    if (s.cyc !== 1'b0 || s.stb !== 1'b0 || grant !== 2'b00) begin
      miscompares++; $display("FAIL arst_drop: got cyc=%b stb=%b grant=%b want 0 0 00", s.cyc, s.stb, grant);
    end
    next_cycle();
    mc[0] = 0; ms[0] = 0; mc[1] = 1; ms[1] = 1; drive_masters();
    sys_rst = 0;
    next_cycle();
    #1;
    vectors++;
    if (grant !== 2'b10) begin miscompares++; $display("FAIL arst_regrant: got %b want 10", grant); end
    clear_masters();
    next_cycle();
  endtask

  task automatic test_random();
    logic        ec, es, ew;
    logic [31:0] ea, ed;
    logic [3:0]  esel;
    logic [2:0]  ecti;
    logic [1:0]  ebte;
    int          r;
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!mc[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            mc[i] = 1; ms[i] = 1; mw[i] = 1'($urandom); ma[i] = $urandom & 32'hffff_fffc;
            md[i] = $urandom; msel[i] = 4'($urandom); mcti[i] = 3'($urandom); mbte[i] = 2'($urandom);
            beats[i] = $urandom_range(1, 4);
          end
        end else if (resp[i]) begin
          beats[i]--;
          if (beats[i] == 0) begin mc[i] = 0; ms[i] = 0; end
          else begin ma[i] = ma[i] + 4; md[i] = $urandom; ms[i] = ($urandom_range(0, 3) != 0); end
        end else if (!ms[i]) begin
          ms[i] = 1'($urandom_range(0, 1));
        end
      end
      drive_masters();
      if (own >= 0) begin
        ec = mc[own]; es = ms[own]; ew = mw[own]; ea = ma[own]; ed = md[own];
        esel = msel[own]; ecti = mcti[own]; ebte = mbte[own];
      end else begin
        ec = 0; es = 0; ew = 0; ea = '0; ed = '0; esel = '0; ecti = '0; ebte = '0;
      end
      s_ack = 0; s_err = 0; s_rty = 0; s_dat = $urandom;
      if (ec && es) begin
        r = $urandom_range(0, 9);
        s_ack = (r < 6); s_err = (r == 6); s_rty = (r == 7);
      end else if (own < 0) begin
        s_ack = ($urandom_range(0, 7) == 0);
      end
      drive_slave();
      #1;
      vectors++;
      if (grant !== own2g(own)) begin miscompares++; $display("FAIL rnd_grant: cycle %0d got %b want %b", n, grant, own2g(own)); end
      vectors++;
      if (s.cyc !== ec || s.stb !== es || s.we !== ew) begin
        miscompares++; $display("FAIL rnd_ctrl: cycle %0d got cyc=%b stb=%b we=%b want %b %b %b", n, s.cyc, s.stb, s.we, ec, es, ew);
      end
      vectors++;
      if (s.adr !== ea || s.dat_ms !== ed) begin
        miscompares++; $display("FAIL rnd_adr_dat: cycle %0d got %h/%h want %h/%h", n, s.adr, s.dat_ms, ea, ed);
      end
      vectors++;
      if (s.sel !== esel || s.cti !== ecti || s.bte !== ebte) begin
        miscompares++; $display("FAIL rnd_tags: cycle %0d got sel=%h cti=%h bte=%h want %h %h %h", n, s.sel, s.cti, s.bte, esel, ecti, ebte);
      end
      vectors++;
      if (m0.ack !== (own == 0 && s_ack) || m1.ack !== (own == 1 && s_ack)) begin
        miscompares++; $display("FAIL rnd_ack: cycle %0d got %b%b want %b%b", n, m1.ack, m0.ack, own == 1 && s_ack, own == 0 && s_ack);
      end
      vectors++;
      if (m0.err !== (own == 0 && s_err) || m1.err !== (own == 1 && s_err)) begin
        miscompares++; $display("FAIL rnd_err: cycle %0d got %b%b want %b%b", n, m1.err, m0.err, own == 1 && s_err, own == 0 && s_err);
      end
      vectors++;
      if (m0.rty !== (own == 0 && s_rty) || m1.rty !== (own == 1 && s_rty)) begin
        miscompares++; $display("FAIL rnd_rty: cycle %0d got %b%b want %b%b", n, m1.rty, m0.rty, own == 1 && s_rty, own == 0 && s_rty);
      end
      vectors++;
      if (m0.dat_sm !== s_dat || m1.dat_sm !== s_dat) begin
        miscompares++; $display("FAIL rnd_dat_sm: cycle %0d got %h/%h want %h", n, m0.dat_sm, m1.dat_sm, s_dat);
      end
      resp[0] = (own == 0) && (s_ack || s_err || s_rty);
      resp[1] = (own == 1) && (s_ack || s_err || s_rty);
      next_cycle();
    end
    clear_masters();
    s_ack = 0; s_err = 0; s_rty = 0; drive_slave();
    next_cycle();
  endtask

  initial begin
    sys_rst = 1;
    own = -1; prio_m = 0;
    clear_masters();
    s_ack = 0; s_err = 0; s_rty = 0; s_dat = '0; drive_slave();
    @(negedge sys_clk);
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_wait();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
